// File: rtl/npn_eval_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npn_eval_pkg
// Description : Shared sizing constants, permutation vector type and the
//               permutation helper functions for the NPN LUT evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
package npn_eval_pkg;

    localparam int NIN_DEFAULT  = 4;
    localparam int TT_W_DEFAULT = 2 ** NIN_DEFAULT;
    localparam int PW_DEFAULT   = $clog2(NIN_DEFAULT);

    // Sized for the widest legal instance (NIN=6, PW=3) so one type serves all.
    localparam int MAX_NIN = 6;
    localparam int MAX_PW  = 3;

    typedef logic [MAX_NIN*MAX_PW-1:0] perm_t;

    function automatic perm_t identity_perm(input int nin, input int pw);
        perm_t r;
        r = '0;
        for (int i = 0; i < MAX_NIN; i++) begin
            for (int b = 0; b < MAX_PW; b++) begin
                if (i < nin && b < pw) begin
                    r[i*pw+b] = i[b];
                end
            end
        end
        return r;
    endfunction

    function automatic logic perm_is_bijection(input perm_t perm, input int nin, input int pw);
        logic [MAX_NIN-1:0] seen;
        logic               ok;
        int                 idx;
        seen = '0;
        ok   = 1'b1;
        for (int i = 0; i < MAX_NIN; i++) begin
            if (i < nin) begin
                idx = 0;
                for (int b = 0; b < MAX_PW; b++) begin
                    if (b < pw && perm[i*pw+b]) begin
                        idx = idx | (1 << b);
                    end
                end
                if (idx >= nin) begin
                    ok = 1'b0;
                end else if (seen[idx]) begin
                    ok = 1'b0;
                end else begin
                    seen[idx] = 1'b1;
                end
            end
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/npn_lut_eval_if.sv
`default_nettype none
// ============================================================================
// Module      : npn_lut_eval_if
// Description : Configuration, input-vector and result handshakes of the
//               NPN LUT evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
interface npn_lut_eval_if
    import npn_eval_pkg::*;
#(
    parameter int NIN = NIN_DEFAULT
);
    localparam int TT_W = 2 ** NIN;
    localparam int PW   = $clog2(NIN);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [TT_W-1:0]   cfg_tt;
    logic [NIN*PW-1:0] cfg_perm;
    logic [NIN-1:0]    cfg_neg_in;
    logic              cfg_neg_out;
    logic              cfg_err;
    logic              in_valid;
    logic              in_ready;
    logic [NIN-1:0]    in_x;
    logic              out_valid;
    logic              out_ready;
    logic              out_y;

    modport master (
        output cfg_valid, cfg_tt, cfg_perm, cfg_neg_in, cfg_neg_out,
        output in_valid, in_x, out_ready,
        input  cfg_ready, cfg_err, in_ready, out_valid, out_y
    );

    modport slave (
        input  cfg_valid, cfg_tt, cfg_perm, cfg_neg_in, cfg_neg_out,
        input  in_valid, in_x, out_ready,
        output cfg_ready, cfg_err, in_ready, out_valid, out_y
    );

endinterface
`default_nettype wire

// File: rtl/npn_xform.sv
`default_nettype none
// ============================================================================
// Module      : npn_xform
// Description : Combinational input negation followed by input permutation.
// Revision    : 1.0 - initial release
// ============================================================================
module npn_xform
    import npn_eval_pkg::*;
#(
    parameter int NIN = NIN_DEFAULT,
    parameter int PW  = $clog2(NIN)
) (
    input  logic [NIN-1:0]    in_x,
    input  logic [NIN-1:0]    neg_in,
    input  logic [NIN*PW-1:0] perm,
    output logic [NIN-1:0]    p
);

    logic [NIN-1:0] w_xn;

    assign w_xn = in_x ^ neg_in;

    // Field i names the source input that lands in position i.
    for (genvar i = 0; i < NIN; i++) begin : g_perm
        assign p[i] = w_xn[perm[i*PW +: PW]];
    end

endmodule
`default_nettype wire

// File: rtl/npn_lut_eval.sv
`default_nettype none
// ============================================================================
// Module      : npn_lut_eval
// Description : Two-stage NPN-transformed truth-table evaluator with a
//               validated, drain-gated configuration port.
// Revision    : 1.0 - initial release
// ============================================================================
module npn_lut_eval
    import npn_eval_pkg::*;
#(
    parameter int NIN = NIN_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    npn_lut_eval_if.slave  bus
);

    localparam int    TT_W            = 2 ** NIN;
    localparam int    PW              = $clog2(NIN);
    localparam perm_t c_identity_perm = identity_perm(NIN, PW);

    logic [TT_W-1:0]   r_cfg_tt;
    logic [NIN*PW-1:0] r_cfg_perm;
    logic [NIN-1:0]    r_cfg_neg_in;
    logic              r_cfg_neg_out;
    logic              r_cfg_err;

    logic              r_s1_valid;
    logic [NIN-1:0]    r_s1_p;
    logic              r_s2_valid;
    logic              r_s2_y;

    logic              w_s2_free;
    logic              w_s1_adv;
    logic              w_in_fire;
    logic              w_cfg_fire;
    logic              w_perm_ok;
    logic [NIN-1:0]    w_p;

    assign w_s2_free  = !r_s2_valid || bus.out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_free;
    // Configuration wins over input; it is only ever taken on an empty pipe.
    assign bus.in_ready  = !rst && !bus.cfg_valid && (!r_s1_valid || w_s1_adv);
    assign bus.cfg_ready = !rst && !r_s1_valid && !r_s2_valid;
    assign w_in_fire  = bus.in_valid && bus.in_ready;
    assign w_cfg_fire = bus.cfg_valid && bus.cfg_ready;
    assign w_perm_ok  = perm_is_bijection(perm_t'(bus.cfg_perm), NIN, PW);

    assign bus.out_valid = r_s2_valid;
    assign bus.out_y     = r_s2_y;
    assign bus.cfg_err   = r_cfg_err;

    npn_xform #(
        .NIN (NIN),
        .PW  (PW)
    ) u_xform (
        .in_x   (bus.in_x),
        .neg_in (r_cfg_neg_in),
        .perm   (r_cfg_perm),
        .p      (w_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_tt      <= '0;
            r_cfg_perm    <= c_identity_perm[NIN*PW-1:0];
            r_cfg_neg_in  <= '0;
            r_cfg_neg_out <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_cfg_err <= w_cfg_fire && !w_perm_ok;
            if (w_cfg_fire && w_perm_ok) begin
                r_cfg_tt      <= bus.cfg_tt;
                r_cfg_perm    <= bus.cfg_perm;
                r_cfg_neg_in  <= bus.cfg_neg_in;
                r_cfg_neg_out <= bus.cfg_neg_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_p     <= '0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_p     <= w_p;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_y     <= 1'b0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_y <= r_cfg_tt[r_s1_p] ^ r_cfg_neg_out;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_npn_lut_eval.sv
`default_nettype none
// ============================================================================
// Module      : tb_npn_lut_eval
// Description : Directed vector table plus hand-written stall, reject and
//               reset sequences for npn_lut_eval (NIN=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npn_lut_eval;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    npn_lut_eval_if #(.NIN(4)) bus ();

    npn_lut_eval #(.NIN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] tt;
        logic [7:0]  perm;
        logic [3:0]  ni;
        logic        no;
        logic [3:0]  x;
        logic        y;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Tasks start and end at one time unit past a rising edge.
    task automatic do_cfg(input logic [15:0] tt, input logic [7:0] perm, input logic [3:0] ni,
                          input logic no, input logic exp_err, input string name);
        int n;
        n = 0;
        bus.cfg_valid   = 1'b1;
        bus.cfg_tt      = tt;
        bus.cfg_perm    = perm;
        bus.cfg_neg_in  = ni;
        bus.cfg_neg_out = no;
        #1;
        while (!bus.cfg_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_cfg_ready"}, 32'(bus.cfg_ready), 32'd1);
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        check({name, "_cfg_err"}, 32'(bus.cfg_err), 32'(exp_err));
        @(posedge clk); #1;
        check({name, "_cfg_err_clear"}, 32'(bus.cfg_err), 32'd0);
    endtask

    task automatic send_one(input logic [3:0] x, input logic exp, input string name);
        int   n;
        logic lat1;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        #1;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_x     = 4'h0;
        lat1 = bus.out_valid;
        @(posedge clk); #1;
        check({name, "_latency"}, 32'({lat1, bus.out_valid}), 32'b01);
        check({name, "_y"}, 32'(bus.out_y), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [9];
        logic [3:0] bp_x   [4];
        logic       bp_exp [4];
        logic       rec    [4];
        int         nrec;
        int         idx;
        int         bad;
        int         seen_ov;
        int         n;
        logic       acc;

        checks   = 0;
        failures = 0;

        vecs[0] = '{16'h8000, 8'hE4, 4'h0, 1'b0, 4'hF, 1'b1};
        vecs[1] = '{16'h8000, 8'hE4, 4'h0, 1'b0, 4'hE, 1'b0};
        vecs[2] = '{16'h8000, 8'hE4, 4'h0, 1'b1, 4'hF, 1'b0};
        vecs[3] = '{16'hAAAA, 8'hE4, 4'h1, 1'b0, 4'h0, 1'b1};
        vecs[4] = '{16'hAAAA, 8'hE1, 4'h0, 1'b0, 4'h2, 1'b1};
        vecs[5] = '{16'hAAAA, 8'hE1, 4'h0, 1'b0, 4'h1, 1'b0};
        vecs[6] = '{16'h0001, 8'hE4, 4'hF, 1'b0, 4'hF, 1'b1};
        vecs[7] = '{16'h0002, 8'h1B, 4'h0, 1'b0, 4'h8, 1'b1};
        vecs[8] = '{16'h6996, 8'hE4, 4'h0, 1'b0, 4'h7, 1'b1};

        bp_x[0] = 4'h1; bp_exp[0] = 1'b1;
        bp_x[1] = 4'h2; bp_exp[1] = 1'b0;
        bp_x[2] = 4'h4; bp_exp[2] = 1'b0;
        bp_x[3] = 4'h3; bp_exp[3] = 1'b1;

        rst             = 1'b1;
        bus.cfg_valid   = 1'b0;
        bus.cfg_tt      = '0;
        bus.cfg_perm    = '0;
        bus.cfg_neg_in  = '0;
        bus.cfg_neg_out = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_x        = '0;
        bus.out_ready   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_y",     32'(bus.out_y),     32'd0);
        check("rst_cfg_err",   32'(bus.cfg_err),   32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("post_rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);

        // Reset configuration: tt=0 so every vector evaluates to 0.
        send_one(4'hF, 1'b0, "reset_cfg_f");
        send_one(4'h5, 1'b0, "reset_cfg_5");

        for (int i = 0; i < 9; i++) begin
            do_cfg(vecs[i].tt, vecs[i].perm, vecs[i].ni, vecs[i].no, 1'b0, $sformatf("vec%0d", i));
            send_one(vecs[i].x, vecs[i].y, $sformatf("vec%0d", i));
        end

        // Rejected requests leave the AND4 configuration in place.
        do_cfg(16'h8000, 8'hE4, 4'h0, 1'b0, 1'b0, "and4");
        do_cfg(16'h0000, 8'hE0, 4'h0, 1'b1, 1'b1, "bad_e0");
        send_one(4'hF, 1'b1, "after_bad_e0");
        do_cfg(16'hFFFF, 8'hE5, 4'hF, 1'b1, 1'b1, "bad_e5");
        send_one(4'hE, 1'b0, "after_bad_e5");

        // Backpressure: out_ready low for six cycles while four vectors are offered.
        do_cfg(16'hAAAA, 8'hE4, 4'h0, 1'b0, 1'b0, "bp");
        idx  = 0;
        nrec = 0;
        for (int cyc = 0; cyc < 40 && nrec < 4; cyc++) begin
            bus.out_ready = (cyc >= 6);
            bus.in_valid  = (idx < 4);
            bus.in_x      = bp_x[(idx < 4) ? idx : 0];
            #1;
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                rec[nrec] = bus.out_y;
                nrec++;
            end
            if (cyc == 2) begin
                check("bp_stall_y_early", 32'({bus.out_valid, bus.out_y}), 32'({1'b1, bp_exp[0]}));
            end
            if (cyc == 5) begin
                check("bp_accepted_count", 32'(idx), 32'd2);
                check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
                check("bp_stall_y_late", 32'({bus.out_valid, bus.out_y}), 32'({1'b1, bp_exp[0]}));
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        bus.in_valid = 1'b0;
        check("bp_received_count", 32'(nrec), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_order%0d", k), 32'(rec[k]), 32'(bp_exp[k]));
        end

        // Reset with two vectors in flight.
        do_cfg(16'hFFFF, 8'hE4, 4'h0, 1'b0, 1'b0, "pre_rst");
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_x      = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("inflight_out_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("mid_rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        seen_ov = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid) seen_ov++;
            @(posedge clk); #1;
        end
        check("mid_rst_no_out", 32'(seen_ov), 32'd0);
        send_one(4'hF, 1'b0, "mid_rst_cfg_f");
        send_one(4'h6, 1'b0, "mid_rst_cfg_6");

        // Configuration requested while a result is stalled must wait for drain.
        do_cfg(16'hFFFF, 8'hE4, 4'h0, 1'b0, 1'b0, "busy_pre");
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_x      = 4'h0;
        @(posedge clk); #1;
        bus.in_valid    = 1'b0;
        bus.cfg_valid   = 1'b1;
        bus.cfg_tt      = 16'h0000;
        bus.cfg_perm    = 8'hE4;
        bus.cfg_neg_in  = 4'h0;
        bus.cfg_neg_out = 1'b0;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (bus.cfg_ready || bus.in_ready) bad++;
            @(posedge clk); #1;
        end
        check("busy_cfg_held_off", 32'(bad), 32'd0);
        check("busy_old_result", 32'({bus.out_valid, bus.out_y}), 32'b11);
        bus.out_ready = 1'b1;
        #1;
        n = 0;
        while (!bus.cfg_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_cfg_ready_after_drain", 32'(bus.cfg_ready), 32'd1);
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        check("busy_cfg_err", 32'(bus.cfg_err), 32'd0);
        send_one(4'h0, 1'b0, "busy_new_cfg");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
